// File: rtl/control_logic_8259.sv
// Control and sequencing core of an 8259A-compatible interrupt controller.
// Define POLL_COMMAND_EN to enable the OCW3 poll command.
module control_logic_8259 (
  input  logic       clock,
  input  logic       reset_n,
  inout  wire  [2:0] cascade_inout,
  inout  wire        slave_program_or_enable_buffer,
  input  logic       interrupt_acknowledge_n,
  input  logic [7:0] internal_data_bus,
  input  logic       write_initial_command_word_1,
  input  logic       write_initial_command_word_2_4,
  input  logic       write_operation_control_word_1,
  input  logic       write_operation_control_word_2,
  input  logic       write_operation_control_word_3,
  input  logic       read,
  input  logic       write,
  input  logic [7:0] interrupt,
  input  logic [7:0] highest_level_in_service,
  output logic       out_control_logic_data,
  output logic [7:0] control_logic_data,
  output logic       interrupt_to_cpu,
  output logic       level_or_edge_triggered_config,
  output logic       special_fully_nest_config,
  output logic       enable_read_register,
  output logic       read_register_isr_or_irr,
  output logic [7:0] interrupt_mask,
  output logic [7:0] interrupt_special_mask,
  output logic [7:0] end_of_interrupt,
  output logic [2:0] priority_rotate,
  output logic       freeze,
  output logic       latch_in_service,
  output logic [7:0] clear_interrupt_request
);

  typedef enum logic [1:0] {CMD_READY, CMD_ICW2, CMD_ICW3, CMD_ICW4} cmd_state_t;

  cmd_state_t cmd_q, cmd_d;
  logic       ic4_q, ic4_d, sngl_q, sngl_d, adi_q, adi_d, ltim_q, ltim_d;
  logic [2:0] vec_hi_q, vec_hi_d;
  logic [7:0] icw2_q, icw2_d, icw3_q, icw3_d;
  logic       upm_q, upm_d, aeoi_q, aeoi_d, buf_q, buf_d, ms_q, ms_d, sfnm_q, sfnm_d;
  logic [7:0] imr_q, imr_d;
  logic       smm_q, smm_d;
  logic [2:0] rot_q, rot_d;
  logic       rot_aeoi_q, rot_aeoi_d;
  logic       rd_isr_q, rd_isr_d, rd_en_q, rd_en_d;
  logic [7:0] eoi_q, eoi_d, clr_irr_q, clr_irr_d;
  logic       lis_q, lis_d, int_q, int_d, freeze_q, freeze_d;
  logic       ack_q, ack_d;
  logic [1:0] cnt_q, cnt_d;
  logic [2:0] lvl_q, lvl_d;
  logic       inta_n_q, sp_q;
  logic [4:0] strb_q, strb_w, strb_p;

  logic       inta_fall, inta_rise, seq_end, master_w;
  logic       inta_low, op_pulse, vec_pulse, vec_ok, ack_drive, cas_drv;
  logic [1:0] last_cnt;
  logic [7:0] byte_mux;

`ifdef POLL_COMMAND_EN
  logic       read_q, poll_q, poll_d, poll_rd_q, poll_rd_d;
  logic [7:0] poll_byte_q, poll_byte_d;
`else
  logic       read_unused;
  assign read_unused = read;
`endif

  function automatic logic [2:0] idx8(input logic [7:0] v);
    idx8 = 3'd7;
    for (int i = 7; i >= 0; i--)
      if (v[i]) idx8 = i[2:0];
  endfunction

  function automatic logic [7:0] onehot8(input logic [2:0] n);
    onehot8 = 8'b1 << n;
  endfunction

  assign strb_w = {5{write}} & {write_operation_control_word_3, write_operation_control_word_2,
                               write_operation_control_word_1, write_initial_command_word_2_4,
                               write_initial_command_word_1};
  assign strb_p    = strb_w & ~strb_q;
  assign inta_fall = inta_n_q & ~interrupt_acknowledge_n;
  assign inta_rise = ~inta_n_q & interrupt_acknowledge_n;
  assign last_cnt  = upm_q ? 2'd2 : 2'd3;
  assign seq_end   = ack_q & inta_rise & (cnt_q == last_cnt);

  // SP/ is a static strap; registering it keeps the EN/ output off its own input path.
  assign master_w  = sngl_q | (buf_q ? ms_q : sp_q);
  assign inta_low  = ack_q & ~inta_n_q;
  assign op_pulse  = ~upm_q & (cnt_q == 2'd1);
  assign vec_pulse = upm_q ? (cnt_q == 2'd2) : ((cnt_q == 2'd2) || (cnt_q == 2'd3));
  assign vec_ok    = sngl_q | (master_w ? ~icw3_q[lvl_q] : (cascade_inout == icw3_q[2:0]));
  assign ack_drive = inta_low & ((op_pulse & master_w) | (vec_pulse & vec_ok));
  assign cas_drv   = ack_q & ~sngl_q & master_w & icw3_q[lvl_q];

  always_comb begin
    byte_mux = 8'h00;
    if (upm_q) byte_mux = {icw2_q[7:3], lvl_q};
    else begin
      case (cnt_q)
        2'd1:    byte_mux = 8'hCD;
        2'd2:    byte_mux = adi_q ? {vec_hi_q, lvl_q, 2'b00} : {vec_hi_q[2:1], lvl_q, 3'b000};
        2'd3:    byte_mux = icw2_q;
        default: byte_mux = 8'h00;
      endcase
    end
  end

`ifdef POLL_COMMAND_EN
  assign out_control_logic_data = ack_drive | poll_rd_q;
  assign control_logic_data     = poll_rd_q ? poll_byte_q : (ack_drive ? byte_mux : 8'h00);
`else
  assign out_control_logic_data = ack_drive;
  assign control_logic_data     = ack_drive ? byte_mux : 8'h00;
`endif

  assign cascade_inout                  = cas_drv ? lvl_q : 3'bzzz;
  assign slave_program_or_enable_buffer = buf_q ? ~out_control_logic_data : 1'bz;

  assign interrupt_to_cpu               = int_q;
  assign level_or_edge_triggered_config = ltim_q;
  assign special_fully_nest_config      = sfnm_q;
  assign enable_read_register           = rd_en_q;
  assign read_register_isr_or_irr       = rd_isr_q;
  assign interrupt_mask                 = imr_q;
  assign interrupt_special_mask         = smm_q ? imr_q : 8'h00;
  assign end_of_interrupt               = eoi_q;
  assign priority_rotate                = rot_q;
  assign freeze                         = freeze_q;
  assign latch_in_service               = lis_q;
  assign clear_interrupt_request        = clr_irr_q;

  always_comb begin
    cmd_d = cmd_q;   ic4_d = ic4_q;   sngl_d = sngl_q; adi_d = adi_q;   ltim_d = ltim_q;
    vec_hi_d = vec_hi_q; icw2_d = icw2_q; icw3_d = icw3_q;
    upm_d = upm_q;   aeoi_d = aeoi_q; buf_d = buf_q;   ms_d = ms_q;     sfnm_d = sfnm_q;
    imr_d = imr_q;   smm_d = smm_q;   rot_d = rot_q;   rot_aeoi_d = rot_aeoi_q;
    rd_isr_d = rd_isr_q; rd_en_d = rd_en_q;
    ack_d = ack_q;   cnt_d = cnt_q;   lvl_d = lvl_q;   freeze_d = freeze_q;
    eoi_d = 8'h00;   clr_irr_d = 8'h00; lis_d = 1'b0;
    int_d = ~ack_q & (|interrupt);
`ifdef POLL_COMMAND_EN
    poll_d = poll_q; poll_rd_d = poll_rd_q & read; poll_byte_d = poll_byte_q;
`endif

    if (strb_p[0]) begin
      cmd_d = CMD_ICW2;
      ic4_d = internal_data_bus[0]; sngl_d = internal_data_bus[1];
      adi_d = internal_data_bus[2]; ltim_d = internal_data_bus[3];
      vec_hi_d = internal_data_bus[7:5];
      imr_d = 8'h00; smm_d = 1'b0; rot_d = 3'd7; rot_aeoi_d = 1'b0;
      rd_isr_d = 1'b0; rd_en_d = 1'b1;
      if (!internal_data_bus[0]) begin
        upm_d = 1'b0; aeoi_d = 1'b0; buf_d = 1'b0; ms_d = 1'b0; sfnm_d = 1'b0;
      end
    end else if (strb_p[1]) begin
      case (cmd_q)
        CMD_ICW2: begin
          icw2_d = internal_data_bus;
          cmd_d  = !sngl_q ? CMD_ICW3 : (ic4_q ? CMD_ICW4 : CMD_READY);
        end
        CMD_ICW3: begin
          icw3_d = internal_data_bus;
          cmd_d  = ic4_q ? CMD_ICW4 : CMD_READY;
        end
        CMD_ICW4: begin
          upm_d = internal_data_bus[0]; aeoi_d = internal_data_bus[1];
          ms_d  = internal_data_bus[2]; buf_d  = internal_data_bus[3];
          sfnm_d = internal_data_bus[4];
          cmd_d = CMD_READY;
        end
        default: cmd_d = CMD_READY;
      endcase
    end

    if (strb_p[2]) imr_d = internal_data_bus;

    if (strb_p[3]) begin
      case (internal_data_bus[7:5])
        3'b001: eoi_d = highest_level_in_service;
        3'b011: eoi_d = onehot8(internal_data_bus[2:0]);
        3'b101: begin
          eoi_d = highest_level_in_service;
          rot_d = idx8(highest_level_in_service);
        end
        3'b111: begin
          eoi_d = onehot8(internal_data_bus[2:0]);
          rot_d = internal_data_bus[2:0];
        end
        3'b110: rot_d = internal_data_bus[2:0];
        3'b100: rot_aeoi_d = 1'b1;
        3'b000: rot_aeoi_d = 1'b0;
        default: ;
      endcase
    end

    if (strb_p[4]) begin
      if (internal_data_bus[1]) begin
        rd_isr_d = internal_data_bus[0];
        rd_en_d  = 1'b1;
      end
      if (internal_data_bus[6]) smm_d = internal_data_bus[5];
`ifdef POLL_COMMAND_EN
      if (internal_data_bus[2]) begin
        poll_d  = 1'b1;
        rd_en_d = 1'b0;
      end
`endif
    end

    // First INTA latches the winning level; later falling edges only advance the byte count.
    if (inta_fall) begin
      if (!ack_q) begin
        ack_d = 1'b1; cnt_d = 2'd1; lvl_d = idx8(interrupt);
        freeze_d = 1'b1; lis_d = 1'b1; int_d = 1'b0;
        clr_irr_d = ltim_q ? 8'h00 : interrupt;
      end else if (cnt_q != last_cnt) begin
        cnt_d = cnt_q + 2'd1;
      end
    end

    if (seq_end) begin
      ack_d = 1'b0; cnt_d = 2'd0; freeze_d = 1'b0;
      if (aeoi_q) begin
        eoi_d = highest_level_in_service;
        if (rot_aeoi_q) rot_d = idx8(highest_level_in_service);
      end
    end

`ifdef POLL_COMMAND_EN
    if (poll_q && read && !read_q) begin
      poll_d = 1'b0; poll_rd_d = 1'b1; rd_en_d = 1'b1;
      poll_byte_d = {|interrupt, 4'b0000, idx8(interrupt)};
      lis_d = 1'b1;
      clr_irr_d = ltim_q ? 8'h00 : interrupt;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q <= CMD_READY; ic4_q <= 1'b0; sngl_q <= 1'b0; adi_q <= 1'b0; ltim_q <= 1'b0;
      vec_hi_q <= 3'd0; icw2_q <= 8'h00; icw3_q <= 8'h00;
      upm_q <= 1'b0; aeoi_q <= 1'b0; buf_q <= 1'b0; ms_q <= 1'b0; sfnm_q <= 1'b0;
      imr_q <= 8'h00; smm_q <= 1'b0; rot_q <= 3'd7; rot_aeoi_q <= 1'b0;
      rd_isr_q <= 1'b0; rd_en_q <= 1'b1;
      eoi_q <= 8'h00; clr_irr_q <= 8'h00; lis_q <= 1'b0; int_q <= 1'b0; freeze_q <= 1'b0;
      ack_q <= 1'b0; cnt_q <= 2'd0; lvl_q <= 3'd0;
      inta_n_q <= 1'b1; sp_q <= 1'b1; strb_q <= 5'd0;
`ifdef POLL_COMMAND_EN
      read_q <= 1'b0; poll_q <= 1'b0; poll_rd_q <= 1'b0; poll_byte_q <= 8'h00;
`endif
    end else begin
      cmd_q <= cmd_d; ic4_q <= ic4_d; sngl_q <= sngl_d; adi_q <= adi_d; ltim_q <= ltim_d;
      vec_hi_q <= vec_hi_d; icw2_q <= icw2_d; icw3_q <= icw3_d;
      upm_q <= upm_d; aeoi_q <= aeoi_d; buf_q <= buf_d; ms_q <= ms_d; sfnm_q <= sfnm_d;
      imr_q <= imr_d; smm_q <= smm_d; rot_q <= rot_d; rot_aeoi_q <= rot_aeoi_d;
      rd_isr_q <= rd_isr_d; rd_en_q <= rd_en_d;
      eoi_q <= eoi_d; clr_irr_q <= clr_irr_d; lis_q <= lis_d; int_q <= int_d;
      freeze_q <= freeze_d;
      ack_q <= ack_d; cnt_q <= cnt_d; lvl_q <= lvl_d;
      inta_n_q <= interrupt_acknowledge_n; sp_q <= slave_program_or_enable_buffer;
      strb_q <= strb_w;
`ifdef POLL_COMMAND_EN
      read_q <= read; poll_q <= poll_d; poll_rd_q <= poll_rd_d; poll_byte_q <= poll_byte_d;
`endif
    end
  end

endmodule

// File: tb/tb_control_logic_8259.sv
// Directed bench for control_logic_8259: init sequences, OCW decode and INTA cycles.
module tb_control_logic_8259;

  logic       clock = 1'b0;
  logic       reset_n;
  wire  [2:0] cas_w;
  wire        sp_w;
  logic       sp_drv;
  logic       inta_n;
  logic [7:0] dbus;
  logic       icw1, icw24, ocw1, ocw2, ocw3, rd, wr_en;
  logic [7:0] irq, his;
  logic       out_data;
  logic [7:0] data;
  logic       int_cpu, ltim, sfnm, rd_en, rd_isr;
  logic [7:0] imr, smask, eoi;
  logic [2:0] rot;
  logic       frz, lis;
  logic [7:0] clr_irr;

  int checks = 0;
  int errors = 0;

  assign sp_w = sp_drv ? 1'b1 : 1'bz;

  always #5 clock = ~clock;

  control_logic_8259 dut (
    .clock                          (clock),
    .reset_n                        (reset_n),
    .cascade_inout                  (cas_w),
    .slave_program_or_enable_buffer (sp_w),
    .interrupt_acknowledge_n        (inta_n),
    .internal_data_bus              (dbus),
    .write_initial_command_word_1   (icw1),
    .write_initial_command_word_2_4 (icw24),
    .write_operation_control_word_1 (ocw1),
    .write_operation_control_word_2 (ocw2),
    .write_operation_control_word_3 (ocw3),
    .read                           (rd),
    .write                          (wr_en),
    .interrupt                      (irq),
    .highest_level_in_service       (his),
    .out_control_logic_data         (out_data),
    .control_logic_data             (data),
    .interrupt_to_cpu               (int_cpu),
    .level_or_edge_triggered_config (ltim),
    .special_fully_nest_config      (sfnm),
    .enable_read_register           (rd_en),
    .read_register_isr_or_irr       (rd_isr),
    .interrupt_mask                 (imr),
    .interrupt_special_mask         (smask),
    .end_of_interrupt               (eoi),
    .priority_rotate                (rot),
    .freeze                         (frz),
    .latch_in_service               (lis),
    .clear_interrupt_request        (clr_irr)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s observed %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  // Idle edge first so back-to-back writes of the same strobe are seen as new edges.
  task automatic wr(input int kind, input logic [7:0] d);
    tick();
    dbus = d; wr_en = 1'b1;
    case (kind)
      0: icw1  = 1'b1;
      1: icw24 = 1'b1;
      2: ocw1  = 1'b1;
      3: ocw2  = 1'b1;
      default: ocw3 = 1'b1;
    endcase
    tick();
    wr_en = 1'b0; icw1 = 1'b0; icw24 = 1'b0; ocw1 = 1'b0; ocw2 = 1'b0; ocw3 = 1'b0;
  endtask

  task automatic inta_low();
    inta_n = 1'b0; tick();
  endtask

  task automatic inta_high();
    inta_n = 1'b1; tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; sp_drv = 1'b1; inta_n = 1'b1; dbus = 8'h00;
    icw1 = 1'b0; icw24 = 1'b0; ocw1 = 1'b0; ocw2 = 1'b0; ocw3 = 1'b0;
    rd = 1'b0; wr_en = 1'b0; irq = 8'h00; his = 8'h00;
    repeat (2) tick();
    check("rst_int", 8'(int_cpu), 8'h00);
    check("rst_freeze", 8'(frz), 8'h00);
    check("rst_out", 8'(out_data), 8'h00);
    check("rst_data", data, 8'h00);
    check("rst_imr", imr, 8'h00);
    check("rst_rot", 8'(rot), 8'h07);
    check("rst_rden", 8'(rd_en), 8'h01);
    check("rst_isr", 8'(rd_isr), 8'h00);
    check("rst_eoi", eoi, 8'h00);
    check("rst_lis", 8'(lis), 8'h00);
    check("rst_clr", clr_irr, 8'h00);
    reset_n = 1'b1;
    tick();

    // Single MCS-80 with ADI=1
    wr(0, 8'hF7); wr(1, 8'hFF); wr(1, 8'h00); wr(2, 8'h00);
    check("m80_ltim", 8'(ltim), 8'h00);
    irq = 8'h01; tick();
    check("m80_int", 8'(int_cpu), 8'h01);
    inta_low();
    check("m80_int_clr", 8'(int_cpu), 8'h00);
    check("m80_freeze", 8'(frz), 8'h01);
    check("m80_lis", 8'(lis), 8'h01);
    check("m80_clr", clr_irr, 8'h01);
    check("m80_out1", 8'(out_data), 8'h01);
    check("m80_b1", data, 8'hCD);
    tick();
    check("m80_lis_pulse", 8'(lis), 8'h00);
    check("m80_clr_pulse", clr_irr, 8'h00);
    inta_high();
    check("m80_out_idle", 8'(out_data), 8'h00);
    inta_low();
    check("m80_b2", data, 8'hE0);
    inta_high();
    inta_low();
    check("m80_b3", data, 8'hFF);
    check("m80_freeze3", 8'(frz), 8'h01);
    inta_high();
    check("m80_freeze_end", 8'(frz), 8'h00);
    irq = 8'h00;

    // Non-specific EOI, strobe held for two edges
    his = 8'h04;
    tick();
    dbus = 8'h20; wr_en = 1'b1; ocw2 = 1'b1;
    tick();
    check("ns_eoi", eoi, 8'h04);
    check("ns_rot", 8'(rot), 8'h07);
    tick();
    check("ns_eoi_once", eoi, 8'h00);
    wr_en = 1'b0; ocw2 = 1'b0;

    // Rotate on non-specific EOI
    his = 8'h01;
    wr(3, 8'hA0);
    check("rot_eoi", eoi, 8'h01);
    check("rot_val", 8'(rot), 8'h00);
    wr(3, 8'h63);
    check("sp_eoi", eoi, 8'h08);

    // Masks and read-register select
    wr(2, 8'h5A);
    check("imr", imr, 8'h5A);
    check("smask_off", smask, 8'h00);
    wr(4, 8'h68);
    check("smask_on", smask, 8'h5A);
    wr(4, 8'h0B);
    check("rd_isr", 8'(rd_isr), 8'h01);

    // 8086 mode; ICW1 clears mask, rotation and register select
    wr(0, 8'h17);
    check("icw1_imr", imr, 8'h00);
    check("icw1_rot", 8'(rot), 8'h07);
    check("icw1_isr", 8'(rd_isr), 8'h00);
    check("icw1_smask", smask, 8'h00);
    wr(1, 8'hF8); wr(1, 8'h01);
    irq = 8'h01; tick();
    inta_low();
    check("x86_out1", 8'(out_data), 8'h00);
    check("x86_freeze", 8'(frz), 8'h01);
    inta_high();
    inta_low();
    check("x86_out2", 8'(out_data), 8'h01);
    check("x86_vec", data, 8'hF8);
    inta_high();
    check("x86_freeze_end", 8'(frz), 8'h00);

    // No request pending: level 7
    irq = 8'h00; tick();
    inta_low();
    check("l7_clr", clr_irr, 8'h00);
    inta_high();
    inta_low();
    check("l7_vec", data, 8'hFF);
    inta_high();

    // Level-triggered with automatic EOI
    wr(0, 8'h1F); wr(1, 8'hF8); wr(1, 8'h03);
    check("lt_ltim", 8'(ltim), 8'h01);
    irq = 8'h04; his = 8'h04; tick();
    inta_low();
    check("lt_clr", clr_irr, 8'h00);
    check("lt_lis", 8'(lis), 8'h01);
    inta_high();
    inta_low();
    check("lt_vec", data, 8'hFA);
    inta_high();
    check("aeoi_eoi", eoi, 8'h04);
    check("aeoi_freeze", 8'(frz), 8'h00);
    irq = 8'h00; his = 8'h00;

    // Cascade master with slaves on every level
    wr(0, 8'hF5); wr(1, 8'hFF); wr(1, 8'hFF); wr(1, 8'h00);
    irq = 8'h01; tick();
    inta_low();
    check("cas_lvl0", 8'(cas_w), 8'h00);
    check("cas_out1", 8'(out_data), 8'h01);
    check("cas_b1", data, 8'hCD);
    inta_high();
    inta_low();
    check("cas_out2", 8'(out_data), 8'h00);
    inta_high();
    inta_low();
    check("cas_out3", 8'(out_data), 8'h00);
    inta_high();
    irq = 8'h20; tick();
    inta_low();
    check("cas_lvl5", 8'(cas_w), 8'h05);
    check("cas5_b1", data, 8'hCD);
    inta_high();
    inta_low(); inta_high();
    inta_low(); inta_high();
    check("cas_freeze_end", 8'(frz), 8'h00);

    // Reset in the middle of an acknowledge
    wr(2, 8'hFF); wr(3, 8'hC3);
    check("pre_rot", 8'(rot), 8'h03);
    irq = 8'h01; tick();
    inta_low();
    check("pre_freeze", 8'(frz), 8'h01);
    #2 reset_n = 1'b0;
    #1;
    check("ra_freeze", 8'(frz), 8'h00);
    check("ra_imr", imr, 8'h00);
    check("ra_rot", 8'(rot), 8'h07);
    inta_n = 1'b1; irq = 8'h00;
    tick();
    reset_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_logic_8259.md
Name: control_logic_8259

Overview:
- Control/sequencing core of an 8259A-compatible programmable interrupt controller.
- Decodes ICW1–ICW4 and OCW1–OCW3 strobes from the bus-control block.
- Holds configuration, drives INT to the CPU, and sequences the INTA cycles (MCS-80/85 and 8086 modes).
- Generates control pulses for the IRR, ISR and priority-resolver blocks, and drives the cascade bus.

Parameters:
- None.

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- cascade_inout  inout  3  CAS2..0: master drives, slave reads
- slave_program_or_enable_buffer  inout  1  non-buffered: SP/ input (1=master); buffered: EN/ output, low while driving data
- interrupt_acknowledge_n  in  1  INTA/ from CPU
- internal_data_bus  in  8  write data
- write_initial_command_word_1  in  1  ICW1 strobe
- write_initial_command_word_2_4  in  1  ICW2/3/4 strobe
- write_operation_control_word_1/2/3  in  1 each  OCW strobes
- read  in  1  CPU read
- write  in  1  CPU write; strobes valid only with write=1
- interrupt  in  8  one-hot winning request from priority resolver
- highest_level_in_service  in  8  one-hot highest ISR bit
- out_control_logic_data  out  1  1 = control_logic_data owns the data bus
- control_logic_data  out  8  vector/opcode/poll byte
- interrupt_to_cpu  out  1  INT
- level_or_edge_triggered_config  out  1  ICW1.LTIM
- special_fully_nest_config  out  1  ICW4.SFNM
- enable_read_register  out  1  OCW3 read-register enable
- read_register_isr_or_irr  out  1  1=ISR, 0=IRR
- interrupt_mask  out  8  IMR
- interrupt_special_mask  out  8  special-mask bits
- end_of_interrupt  out  8  one-cycle ISR clear pulse, one-hot
- priority_rotate  out  3  lowest-priority level
- freeze  out  1  hold IRR/priority during ack
- latch_in_service  out  1  one-cycle ISR set pulse
- clear_interrupt_request  out  8  one-cycle IRR clear, one-hot

Behaviour:
- Reset values:
  - All outputs 0, except priority_rotate=7 and enable_read_register=1 (IRR selected).
  - Command state = READY.
  - Cascade and EN/ released.
- Strobes are detected on a 0→1 edge, sampled on clock with write=1. Each strobe is acted on once.
- ICW1: state→ICW2. Also sets:
  - IC4=D0, SNGL=D1, ADI=D2, LTIM=D3, A7..5=D7..5.
  - interrupt_mask←0, special mask off, priority_rotate←7, read register←IRR.
  - If IC4=0, ICW4 fields are cleared.
- ICW2: latches D7..0. Next state:
  - ICW3 if SNGL=0;
  - otherwise ICW4 if IC4=1;
  - otherwise READY.
- ICW3: latches master slave-mask or slave ID (D2..0). Next state is ICW4 if IC4=1, else READY.
- ICW4: uPM=D0, AEOI=D1, BUF/MS=D3..2, SFNM=D4. State→READY.
- OCW1: interrupt_mask←D.
- OCW2, decoded on D7..5:
  - 001: end_of_interrupt←highest_level_in_service.
  - 011: end_of_interrupt←onehot(D2..0).
  - 101: same as 001, plus priority_rotate←index of highest_level_in_service.
  - 111: onehot EOI plus priority_rotate←D2..0.
  - 110: priority_rotate←D2..0.
  - 100/000: set/clear rotate-in-AEOI.
  - 010: no-op.
- OCW3:
  - RR=1: read_register_isr_or_irr←RIS.
  - ESMM=1: special mask←SMM. When on, interrupt_special_mask←interrupt_mask; when off, it is 0.
- INT: interrupt_to_cpu←1 when interrupt≠0 and no ack is active. It clears on the first INTA falling edge.
- INTA sequence (falling edges counted):
  - First INTA:
    - freeze=1; latch_in_service one-cycle pulse.
    - clear_interrupt_request←interrupt one-cycle (edge mode only).
    - Master drives cascade with the level index if the mask bit is set.
  - MCS-80 mode (uPM=0), 3 pulses:
    - byte1 = 0xCD;
    - byte2 = ADI ? {A7..5, lvl, 00} : {A7..6, lvl, 000};
    - byte3 = ICW2.
  - 8086 mode, 2 pulses:
    - pulse 1: no data;
    - pulse 2: {ICW2[7:3], lvl}.
  - out_control_logic_data=1 while INTA low on a data pulse.
  - A master whose level has a slave does not drive vector bytes.
  - A slave drives the vector bytes only when CAS equals its ID.
- End of sequence (last INTA rising edge):
  - freeze←0.
  - If AEOI: end_of_interrupt←highest_level_in_service, plus rotation if enabled.
- INTA asserted with interrupt=0: vector uses level 7.
- reset_n asserted mid-sequence aborts to reset values.

Optional Feature:
- Macro POLL_COMMAND_EN.
- Defined:
  - OCW3 D2=1 arms poll. The next read with poll armed drives {interrupt≠0, 0000, lvl} and acts as the first INTA (latch_in_service, clear_interrupt_request). Then poll is disarmed.
- Undefined: D2 is ignored.

Test Plan:
- Single, MCS-80:
  - Stimulus: ICW1=F7, ICW2=FF, ICW4=00, OCW1=00; interrupt=01.
  - Response: interrupt_to_cpu=1; INTA bytes CD, E0, FF; latch_in_service and clear_interrupt_request=01 pulse on first INTA.
- Rotate: same setup, highest_level_in_service=01, OCW2=A0 → end_of_interrupt=01 pulse, priority_rotate=0.
- Fully nested: OCW2=20, highest_level_in_service=04 → end_of_interrupt=04, priority_rotate unchanged=7.
- 8086:
  - Stimulus: ICW1=17, ICW2=F8, ICW4=01; interrupt=01.
  - Response: 1st INTA no data with freeze=1; 2nd byte F8; freeze=0 after.
- Cascade master: ICW1=F5, ICW2=FF, ICW3=FF, ICW4=00; interrupt=01 → cascade_inout=000 from 1st INTA; byte1 CD; bytes 2/3 not driven.
- reset_n low mid-ack → freeze=0, interrupt_mask=00, priority_rotate=7.
